// File: rtl/axis_fifo.sv
// AXI4-Stream FIFO with optional store-and-forward packet mode.
// Single clock; occupancy and packet counts are registered and exported.
module axis_fifo #(
  parameter int TDATA_BYTES = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int DEPTH       = 16,
  parameter int PACKET_MODE = 0
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [TDATA_BYTES*8-1:0]   s_axis_tdata,
  input  logic [TDATA_BYTES-1:0]     s_axis_tkeep,
  input  logic                       s_axis_tlast,
  input  logic [TUSER_WIDTH-1:0]     s_axis_tuser,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  output logic [TDATA_BYTES*8-1:0]   m_axis_tdata,
  output logic [TDATA_BYTES-1:0]     m_axis_tkeep,
  output logic                       m_axis_tlast,
  output logic [TUSER_WIDTH-1:0]     m_axis_tuser,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     pkt_count
);

  localparam int DW = TDATA_BYTES * 8;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = TUSER_WIDTH + TDATA_BYTES + 1 + DW;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] pkt_count_q, pkt_count_d;
  logic          tready_q, tready_d;
  logic          full, empty, push, pop, m_valid;

  always_comb begin
    full  = (count_q == CW'(DEPTH));
    empty = (count_q == '0);
    // In packet mode a full FIFO releases anyway so oversize packets cannot deadlock.
    if (PACKET_MODE != 0) m_valid = !empty && ((pkt_count_q != '0) || full);
    else                  m_valid = !empty;
    push        = s_axis_tvalid && tready_q;
    pop         = m_valid && m_axis_tready;
    wr_ptr_d    = wr_ptr_q + AW'(push);
    rd_ptr_d    = rd_ptr_q + AW'(pop);
    count_d     = count_q + CW'(push) - CW'(pop);
    pkt_count_d = pkt_count_q + CW'(push && s_axis_tlast) - CW'(pop && m_axis_tlast);
    tready_d    = (count_d != CW'(DEPTH));
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pkt_count_q <= '0;
      tready_q    <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pkt_count_q <= pkt_count_d;
      tready_q    <= tready_d;
    end
  end

  // Storage is deliberately not reset; the pointers define what is valid.
  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_ptr_q] <= {s_axis_tuser, s_axis_tkeep, s_axis_tlast, s_axis_tdata};
  end

  assign {m_axis_tuser, m_axis_tkeep, m_axis_tlast, m_axis_tdata} = mem_q[rd_ptr_q];
  assign m_axis_tvalid = m_valid;
  assign s_axis_tready = tready_q;
  assign count         = count_q;
  assign pkt_count     = pkt_count_q;

endmodule

// File: doc/axis_fifo.md
# axis_fifo

Parametrised AXI4-Stream FIFO buffering one stream between a slave port and a master port on a single clock. Carries tdata, tkeep, tlast and tuser, with configurable width and depth. An optional packet (store-and-forward) mode holds output until a complete packet, terminated by tlast, is stored. It is the standard buffering stage between AXIS agents and DUT-side stream logic in our benches and datapaths.

## Interface
- TDATA_BYTES, 1: tdata width in bytes; tkeep width equals TDATA_BYTES.
- TUSER_WIDTH, 1: tuser width in bits (≥1).
- DEPTH, 16: storage entries; power of two, ≥2.
- PACKET_MODE, 0: 0 = cut-through, 1 = store-and-forward.
- aclk  in  1  clock; all state changes on rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  TDATA_BYTES*8  write data.
- s_axis_tkeep  in  TDATA_BYTES  byte qualifiers, stored unmodified.
- s_axis_tlast  in  1  end of packet.
- s_axis_tuser  in  TUSER_WIDTH  sideband, stored unmodified.
- s_axis_tvalid  in  1  write request.
- s_axis_tready  out  1  FIFO can accept a beat.
- m_axis_tdata / m_axis_tkeep / m_axis_tlast / m_axis_tuser  out  as slave side  head-of-FIFO beat.
- m_axis_tvalid  out  1  head beat available.
- m_axis_tready  in  1  downstream accepts.
- count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- pkt_count  out  $clog2(DEPTH)+1  complete packets stored (tlast beats held).

## Operation
- Write: a beat is stored when s_axis_tvalid && s_axis_tready at a rising edge.
- Read: the head beat is popped when m_axis_tvalid && m_axis_tready at a rising edge.
- Storage: circular buffer with wr_ptr/rd_ptr of $clog2(DEPTH) bits that wrap modulo DEPTH. Full/empty come from count (count==DEPTH / count==0), not from pointer equality.
- count next = count + push − pop. A simultaneous push and pop leaves count unchanged.
- pkt_count next = pkt_count + (push && s_axis_tlast) − (pop && m_axis_tlast).
- s_axis_tready = !full.
  - When full, no write is accepted in the same cycle as a pop; the freed slot is writable from the next cycle. There is no full-state write-through.
- m_axis_tvalid:
  - PACKET_MODE=0: !empty.
  - PACKET_MODE=1: !empty && (pkt_count!=0 || full).
  - The `full` term is a forced release. A packet longer than DEPTH would otherwise deadlock, so it drains cut-through instead.
- m_axis_* payload outputs show mem[rd_ptr]. Their value while m_axis_tvalid=0 is don't-care.
- AXIS rules: once m_axis_tvalid is asserted, it and the payload stay stable until the beat is popped. No beat is dropped, duplicated or reordered.
- Reset (aresetn low, any time, including mid-packet): pointers, count and pkt_count clear immediately. Stored data is discarded; memory contents are not cleared.

## Timing
- Reset values while aresetn=0: s_axis_tready=0, m_axis_tvalid=0, count=0, pkt_count=0.
- s_axis_tready is registered. It rises at the first rising edge after aresetn deasserts, then equals !full of the registered count.
- Cut-through latency: a beat written into an empty FIFO at edge k has m_axis_tvalid=1 after edge k (1 cycle). There is no empty-state bypass.
- Packet-mode latency: m_axis_tvalid rises after the edge that writes the tlast beat. The exception is a forced release, where it rises after the edge that makes count==DEPTH.
- Full throughput: with both sides continuously valid/ready and the FIFO neither empty nor full, one beat per cycle passes.
- count and pkt_count are registered and reflect every push/pop after the edge on which it occurs.

## Test plan
- Reset release:
  - Hold aresetn=0 for 5 cycles → s_axis_tready=0, m_axis_tvalid=0, count=0 throughout.
  - After release, s_axis_tready=1 on the first edge.
- Fill/drain (DEPTH=16, PACKET_MODE=0):
  - Write beats 0x00..0x0F with m_axis_tready=0 → count=16 and s_axis_tready=0.
  - A 17th beat held valid is not accepted.
  - Raise m_axis_tready → data emerges 0x00..0x0F in order and count returns to 0.
- Wrap-around and concurrency:
  - Run 100 beats with random valid/ready at ~50% duty on both sides → output sequence equals input sequence, including tkeep/tuser.
  - count never exceeds 16 and never underflows.
- Packet mode (PACKET_MODE=1):
  - Write a 4-beat packet with a 3-cycle gap before tlast → m_axis_tvalid stays 0 until after the tlast edge.
  - Then 4 beats are output with tlast on the 4th, and pkt_count goes 1→0.
- Forced release (PACKET_MODE=1, DEPTH=16):
  - Stream a 20-beat packet → m_axis_tvalid rises when count hits 16.
  - All 20 beats are delivered in order with tlast on beat 20.
- Reset mid-operation:
  - Assert aresetn=0 asynchronously with 7 beats stored → count=0 and m_axis_tvalid=0 without waiting for a clock edge.
  - After release, a new beat 0xA5 is the first beat output.
